approx_mult_rr_scheduler: RTL and testbench

//   Shares one 8x8 unsigned multiplier datapath among NUM_REQ requesters, using

---
 rtl/approx_mult_rr_scheduler_if.sv | 32 +++
 rtl/approx_mult_rr_scheduler.sv | 130 +++++++++++++
 tb/tb_approx_mult_rr_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_rr_scheduler_if.sv
// Bundle shared between the requesting lanes and the multiplier scheduler.
//   req_valid/req_ready  per-requester handshake, one bit per requester
//   req_x/req_y          8-bit operands per requester, packed; requester i uses [8i+7:8i]
//   req_approx           per-requester mode: 1 = l=4 approximate, 0 = exact
//   rsp_valid/rsp_ready  single response handshake
//   rsp_z/rsp_id/rsp_approx  product, issuing requester index, echoed mode
// master = requester/consumer side, slave = scheduler side.
interface approx_mult_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_x;
  logic [8*NUM_REQ-1:0] req_y;
  logic [NUM_REQ-1:0]   req_approx;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [15:0]          rsp_z;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_approx;

  modport master (
    output req_valid, req_x, req_y, req_approx, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id, rsp_approx
  );

  modport slave (
    input  req_valid, req_x, req_y, req_approx, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id, rsp_approx
  );
endinterface

// File: rtl/approx_mult_rr_scheduler.sv
// Round-robin scheduler in front of one shared 8x8 unsigned multiplier.
// Each request picks the exact product or the l=4 approximate product; the
// result comes back two cycles after the handshake, tagged with the requester id.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of approx_mult_rr_scheduler_if (request and response handshakes)
module approx_mult_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  approx_mult_rr_scheduler_if.slave    bus
);

  // Both pipeline stages move together whenever the output can take new data.
  logic adv;
  assign adv = !bus.rsp_valid || bus.rsp_ready;

  // ---------------- arbitration ----------------
  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] win;
  logic            found;
  logic            hs;

  // Scan from ptr upward, wrapping at NUM_REQ; the first valid requester wins.
  always_comb begin
    logic [ID_W:0] cand;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  // A winner always has valid high, so a grant with adv is a handshake.
  assign hs       = found && adv && !rst;
  assign ptr_next = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = hs && (win == ID_W'(gi));
    end
  endgenerate

  // ---------------- stage 1: capture granted operands ----------------
  logic            s1_valid_reg;
  logic [7:0]      s1_x_reg;
  logic [7:0]      s1_y_reg;
  logic [ID_W-1:0] s1_id_reg;
  logic            s1_approx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= '0;
      s1_valid_reg  <= 1'b0;
      s1_x_reg      <= '0;
      s1_y_reg      <= '0;
      s1_id_reg     <= '0;
      s1_approx_reg <= 1'b0;
    end else if (adv) begin
      // A cycle without a handshake leaves a bubble in stage 1.
      s1_valid_reg <= hs;
      if (hs) begin
        ptr_reg       <= ptr_next;
        s1_x_reg      <= bus.req_x[8*win +: 8];
        s1_y_reg      <= bus.req_y[8*win +: 8];
        s1_id_reg     <= win;
        s1_approx_reg <= bus.req_approx[win];
      end
    end
  end

  // ---------------- stage 2: product ----------------
  // Partial-product rows p_k = y & {8{x[k]}} for the four low multiplicand bits;
  // the approximate scheme drops these rows and substitutes fixed correction terms.
  logic [7:0] p [4];
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      assign p[gi] = s1_y_reg & {8{s1_x_reg[gi]}};
    end
  endgenerate

  logic [15:0] z_exact;
  logic [11:0] z_high;
  logic [15:0] t1, t2, t3, t4;
  logic [15:0] z_approx;
  logic [15:0] z_next;

  always_comb begin
    z_exact  = {8'b0, s1_x_reg} * {8'b0, s1_y_reg};
    z_high   = {4'b0, s1_y_reg} * {8'b0, s1_x_reg[7:4]};
    t1       = {5'b0, (p[2][7] & p[3][6]), (p[2][7] ^ p[3][6]), p[1][7],
                (p[0][6] | p[1][5]), 7'b0};
    t2       = {5'b0, p[3][7], 1'b0, (p[2][6] & p[3][5]),
                (p[0][7] | p[1][6]), 7'b0};
    t3       = {7'b0, (p[2][6] | p[3][5]), (p[2][4] | p[3][3]), 7'b0};
    t4       = {8'b0, (p[2][5] | p[3][4]), 7'b0};
    // 16-bit sum: any carry past bit 15 is intentionally lost.
    z_approx = {z_high, 4'b0} + t1 + t2 + t3 + t4;
    z_next   = s1_approx_reg ? z_approx : z_exact;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_z      <= '0;
      bus.rsp_id     <= '0;
      bus.rsp_approx <= 1'b0;
    end else if (adv) begin
      bus.rsp_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        bus.rsp_z      <= z_next;
        bus.rsp_id     <= s1_id_reg;
        bus.rsp_approx <= s1_approx_reg;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_rr_scheduler.sv
module tb_approx_mult_rr_scheduler;

  logic clk;
  logic rst;

  approx_mult_rr_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  approx_mult_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    logic [1:0]  id;
    logic        a;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference products written straight from the arithmetic definition.
  function automatic bit pb(input logic [7:0] x, input logic [7:0] y, input int k, input int j);
    return bit'(x[k] & y[j]);
  endfunction

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic a);
    int acc;
    if (!a) return 16'(int'(x) * int'(y));
    acc = int'(y) * int'(x[7:4]) * 16;
    acc += 128 * (8 * int'(pb(x,y,2,7) & pb(x,y,3,6)) + 4 * int'(pb(x,y,2,7) ^ pb(x,y,3,6))
                  + 2 * int'(pb(x,y,1,7)) + int'(pb(x,y,0,6) | pb(x,y,1,5)));
    acc += 128 * (8 * int'(pb(x,y,3,7)) + 2 * int'(pb(x,y,2,6) & pb(x,y,3,5))
                  + int'(pb(x,y,0,7) | pb(x,y,1,6)));
    acc += 128 * (2 * int'(pb(x,y,2,6) | pb(x,y,3,5)) + int'(pb(x,y,2,4) | pb(x,y,3,3)));
    acc += 128 * int'(pb(x,y,2,5) | pb(x,y,3,4));
    return 16'(acc);
  endfunction

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.z  = model(bus.req_x[8*i +: 8], bus.req_y[8*i +: 8], bus.req_approx[i]);
          e.id = 2'(i);
          e.a  = bus.req_approx[i];
          exp_q.push_back(e);
          grant_log.push_back(i);
          $display("req  id=%0d x=%02h y=%02h approx=%0d", i, bus.req_x[8*i +: 8],
                   bus.req_y[8*i +: 8], bus.req_approx[i]);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        $display("rsp  id=%0d z=%04h approx=%0d", bus.rsp_id, bus.rsp_z, bus.rsp_approx);
        n_checks++;
        assert (exp_q.size() != 0) n_pass++;
        else $error("FAIL rsp_spurious: observed response id=%0d expected none", bus.rsp_id);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_z", 32'(bus.rsp_z), 32'(e.z));
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_approx", 32'(bus.rsp_approx), 32'(e.a));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y, input logic a);
    bus.req_x[8*i +: 8] = x;
    bus.req_y[8*i +: 8] = y;
    bus.req_approx[i]   = a;
  endtask

  // One isolated request from requester i, then the 2-cycle latency checks.
  task automatic single(input string tag, input int i, input logic [7:0] x,
                        input logic [7:0] y, input logic a, input logic [15:0] z_exp);
    set_req(i, x, y, a);
    bus.req_valid = 4'(1 << i);
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << i));
    tick(1);
    bus.req_valid = 4'b0;
    chk({tag, "_lat1_valid"}, 32'(bus.rsp_valid), 32'd0);
    tick(1);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_z"}, 32'(bus.rsp_z), 32'(z_exp));
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(i));
    chk({tag, "_approx"}, 32'(bus.rsp_approx), 32'(a));
    tick(2);
  endtask

  task automatic chk_grants(input string tag, input int exp_g[$]);
    chk({tag, "_count"}, 32'(grant_log.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size(); i++)
      if (i < grant_log.size())
        chk($sformatf("%s_grant%0d", tag, i), 32'(grant_log[i]), 32'(exp_g[i]));
  endtask

  initial begin
    logic [15:0] z0;
    rst            = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_approx = '0;
    bus.rsp_ready  = 1'b1;

    // Reset state, with requests present to show ready is held low.
    tick(2);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_z", 32'(bus.rsp_z), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_approx", 32'(bus.rsp_approx), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 4'b0;
    rst = 1'b0;
    tick(1);

    // Exact and approximate single requests.
    single("exact", 1, 8'h0F, 8'hFF, 1'b0, 16'h0EF1);
    single("approx", 1, 8'h0F, 8'hFF, 1'b1, 16'h0D00);
    single("approx_hi", 1, 8'h10, 8'h0F, 1'b1, 16'h00F0);

    // Bring ptr from 2 to 0, then all four valid continuously.
    single("prep", 3, 8'hA5, 8'h5A, 1'b0, 16'(8'hA5 * 8'h5A));
    for (int i = 0; i < 4; i++)
      set_req(i, 8'($urandom), 8'($urandom), 1'(i % 2));
    grant_log.delete();
    bus.req_valid = 4'hF;
    tick(8);
    bus.req_valid = 4'b0;
    chk_grants("rr", '{0, 1, 2, 3, 0, 1, 2, 3});
    tick(3);
    chk("rr_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure with a response pending.
    for (int i = 0; i < 4; i++)
      set_req(i, 8'($urandom), 8'($urandom), 1'(i == 0));
    z0 = model(bus.req_x[7:0], bus.req_y[7:0], 1'b1);
    grant_log.delete();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    tick(2);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp_z_c%0d", c), 32'(bus.rsp_z), 32'(z0));
      chk($sformatf("bp_id_c%0d", c), 32'(bus.rsp_id), 32'd0);
      chk($sformatf("bp_ready_c%0d", c), 32'(bus.req_ready), 32'd0);
      tick(1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(bus.req_ready), 32'b0100);
    tick(1);
    bus.req_valid = 4'b0;
    chk_grants("bp", '{0, 1, 2});
    tick(4);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Pointer wrap between requesters 3 and 0, then a lone requester 2.
    grant_log.delete();
    bus.req_valid = 4'b1001;
    tick(4);
    bus.req_valid = 4'b0100;
    tick(3);
    bus.req_valid = 4'b0;
    chk_grants("wrap", '{3, 0, 3, 0, 2, 2, 2});
    tick(4);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two requests in flight.
    grant_log.delete();
    bus.req_valid = 4'b0110;
    tick(2);
    bus.req_valid = 4'b0;
    chk("mid_accepted", 32'(grant_log.size()), 32'd2);
    chk("mid_inflight", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mid_no_stale_c%0d", c), 32'(bus.rsp_valid), 32'd0);
      tick(1);
    end
    bus.req_valid = 4'hF;
    #1;
    chk("mid_first_grant", 32'(bus.req_ready), 32'b0001);
    tick(1);
    bus.req_valid = 4'b0;
    tick(4);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
